// File: rtl/mio_responder.sv
// Memory/IO responder: RAM, GPIO and free-running TIMER behind a CPU stall interface.
// Latency: accept edge, then RAM_LAT (RAM) / IO_LAT (GPIO, TIMER) / 1 (unmapped) WAIT cycles, then one DONE cycle.
// Backpressure: MIO_ready is low during WAIT; mem_req is ignored outside IDLE.
//
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   mem_req, mem_w  - level request from the CPU and its direction (1 = write)
//   M_addr          - byte address; bits [1:0] are ignored
//   data_out        - CPU write data
//   data2CPU        - registered read data, held until the next completed read
//   MIO_ready       - 0 stalls the CPU (WAIT), 1 otherwise
//   sw_in           - switch inputs, read through the GPIO address
//   gpio_out        - LED register, written through the GPIO address
//   bus_err         - one-cycle pulse in the DONE cycle of an unmapped access
module mio_responder #(
    parameter int RAM_LAT = 2,
    parameter int IO_LAT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_w,
    input  logic [31:0] M_addr,
    input  logic [31:0] data_out,
    output logic [31:0] data2CPU,
    output logic        MIO_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] gpio_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0]  RAM_WAIT   = 3'(RAM_LAT);
    localparam logic [2:0]  IO_WAIT    = 3'(IO_LAT);
    localparam logic [29:0] GPIO_WORD  = 30'h3C00_0000;  // 0xF000_0000 >> 2
    localparam logic [29:0] TIMER_WORD = 30'h3C00_0001;  // 0xF000_0004 >> 2

    state_t      state, next_state;
    logic        accept;
    logic        commit;
    logic [2:0]  wait_cnt;
    logic        run_q;

    logic [29:0] cap_word;
    logic        cap_w;
    logic [31:0] cap_data;

    logic [29:0] acc_word;
    logic        acc_w;
    logic [31:0] acc_data;
    logic        hit_ram, hit_gpio, hit_timer, hit_none;
    logic [2:0]  acc_lat;
    logic [31:0] rd_mux;
    logic        ram_we;

    logic [31:0] timer;
    logic [31:0] ram [0:63];

    logic        addr_lsb_unused;
    assign addr_lsb_unused = &{1'b0, M_addr[1:0]};

    // In IDLE the access is described by the live inputs (a zero-wait access
    // commits on its own accept edge); afterwards only the captured copy counts.
    assign acc_word = (state == IDLE) ? M_addr[31:2] : cap_word;
    assign acc_w    = (state == IDLE) ? mem_w        : cap_w;
    assign acc_data = (state == IDLE) ? data_out     : cap_data;

    assign hit_ram   = (acc_word[29:6] == 24'h0);
    assign hit_gpio  = (acc_word == GPIO_WORD);
    assign hit_timer = (acc_word == TIMER_WORD);
    assign hit_none  = !(hit_ram || hit_gpio || hit_timer);

    always_comb begin
        acc_lat = 3'd1;
        if (hit_ram) begin
            acc_lat = RAM_WAIT;
        end else if (hit_gpio || hit_timer) begin
            acc_lat = IO_WAIT;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        if (hit_ram) begin
            rd_mux = ram[acc_word[5:0]];
        end else if (hit_gpio) begin
            rd_mux = {16'h0, sw_in};
        end else if (hit_timer) begin
            rd_mux = timer;
        end
    end

    // run_q keeps the block from accepting on an edge where reset is still
    // being released, so nothing can commit while reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && run_q) begin
                    accept = 1'b1;
                    if (acc_lat == 3'd0) begin
                        next_state = DONE;
                        commit     = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    next_state = DONE;
                    commit     = 1'b1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign MIO_ready = (state != WAIT);

    // wait_cnt holds the WAIT cycles still to go after the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 3'd0;
            cap_word <= 30'h0;
            cap_w    <= 1'b0;
            cap_data <= 32'h0;
        end else begin
            if (accept) begin
                cap_word <= M_addr[31:2];
                cap_w    <= mem_w;
                cap_data <= data_out;
                if (acc_lat != 3'd0) begin
                    wait_cnt <= acc_lat - 3'd1;
                end
            end else if (state == WAIT && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data2CPU <= 32'h0;
            gpio_out <= 16'h0;
            timer    <= 32'h0;
            bus_err  <= 1'b0;
        end else begin
            timer   <= timer + 32'd1;
            bus_err <= 1'b0;
            if (commit) begin
                bus_err <= hit_none;
                if (acc_w) begin
                    if (hit_gpio) begin
                        gpio_out <= acc_data[15:0];
                    end
                    if (hit_timer) begin
                        timer <= acc_data;
                    end
                end else begin
                    data2CPU <= rd_mux;
                end
            end
        end
    end

    assign ram_we = commit && acc_w && hit_ram;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[acc_word[5:0]] <= acc_data;
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
module tb_mio_responder;

    localparam int RAM_LAT = 2;
    localparam int IO_LAT  = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_w;
    logic [31:0] M_addr;
    logic [31:0] data_out;
    logic [31:0] data2CPU;
    logic        MIO_ready;
    logic [15:0] sw_in;
    logic [15:0] gpio_out;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    int unsigned cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (reset) cyc <= cyc + 1;

    mio_responder #(.RAM_LAT(RAM_LAT), .IO_LAT(IO_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_w     (mem_w),
        .M_addr    (M_addr),
        .data_out  (data_out),
        .data2CPU  (data2CPU),
        .MIO_ready (MIO_ready),
        .sw_in     (sw_in),
        .gpio_out  (gpio_out),
        .bus_err   (bus_err)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_ram [64];
    bit          m_vld [64];
    logic [15:0] m_gpio;
    logic [31:0] m_rd;
    bit          m_rd_known;
    logic [31:0] m_tbase;
    int unsigned m_tcyc;

    function automatic int region_of(input logic [31:0] addr);
        if (addr < 32'h100) return 0;
        if ((addr & ~32'h3) == 32'hF000_0000) return 1;
        if ((addr & ~32'h3) == 32'hF000_0004) return 2;
        return 3;
    endfunction

    function automatic int lat_of(input logic [31:0] addr);
        case (region_of(addr))
            0:       return RAM_LAT;
            1, 2:    return IO_LAT;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_gpio     = 16'h0;
        m_rd       = 32'h0;
        m_rd_known = 1'b1;
        m_tbase    = 32'h0;
        m_tcyc     = cyc;
    endtask

    // dcyc: bench cycle count observed in the DONE cycle (commit edge already counted)
    task automatic model_access(input logic w, input logic [31:0] addr, input logic [31:0] data,
                                input int unsigned dcyc, output logic [31:0] exp_rd,
                                output bit exp_err, output bit rd_known);
        int i;
        i = int'(addr[7:2]);
        exp_err = 1'b0;
        case (region_of(addr))
            0: begin
                if (w) begin
                    m_ram[i] = data;
                    m_vld[i] = 1'b1;
                end else begin
                    m_rd       = m_ram[i];
                    m_rd_known = m_vld[i];
                end
            end
            1: begin
                if (w) m_gpio = data[15:0];
                else begin
                    m_rd       = {16'h0, sw_in};
                    m_rd_known = 1'b1;
                end
            end
            2: begin
                if (w) begin
                    m_tbase = data;
                    m_tcyc  = dcyc;
                end else begin
                    m_rd       = m_tbase + (dcyc - 1 - m_tcyc);
                    m_rd_known = 1'b1;
                end
            end
            default: begin
                exp_err = 1'b1;
                if (!w) begin
                    m_rd       = 32'h0;
                    m_rd_known = 1'b1;
                end
            end
        endcase
        exp_rd   = m_rd;
        rd_known = m_rd_known;
    endtask

    // Drives one access; scrambles the bus right after the accept edge.
    task automatic do_access(input logic w, input logic [31:0] addr, input logic [31:0] data,
                             output int waits, output bit err_wait, output logic done_err,
                             output logic [31:0] rd, output logic [15:0] gp,
                             output int unsigned dcyc, output bit timeout);
        @(negedge clk);
        mem_req  = 1'b1;
        mem_w    = w;
        M_addr   = addr;
        data_out = data;
        @(posedge clk);
        #1;
        M_addr   = $urandom;
        data_out = $urandom;
        mem_w    = 1'($urandom_range(0, 1));
        waits    = 0;
        err_wait = 1'b0;
        timeout  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (MIO_ready === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            waits++;
            if (bus_err !== 1'b0) err_wait = 1'b1;
        end
        done_err = bus_err;
        rd       = data2CPU;
        gp       = gpio_out;
        dcyc     = cyc;
        mem_req  = 1'b0;
        @(posedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b0;
        mem_req  = 1'b0;
        mem_w    = 1'b0;
        M_addr   = 32'h0;
        data_out = 32'h0;
        sw_in    = 16'h0;
        repeat (3) @(negedge clk);
        total++; if (MIO_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", MIO_ready); end
        total++; if (data2CPU !== 32'h0) begin bad++; $display("FAIL reset_data2CPU got=%h want=0", data2CPU); end
        total++; if (gpio_out !== 16'h0) begin bad++; $display("FAIL reset_gpio got=%h want=0", gpio_out); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_ram();
        int waits; bit ew, to, ee, kn; logic de; logic [31:0] rd, er; logic [15:0] gp; int unsigned dc;
        do_access(1'b1, 32'h10, 32'hDEAD_BEEF, waits, ew, de, rd, gp, dc, to);
        model_access(1'b1, 32'h10, 32'hDEAD_BEEF, dc, er, ee, kn);
        total++; if (to || waits != lat_of(32'h10)) begin bad++; $display("FAIL ram_wr_waits got=%0d timeout=%0b want=%0d", waits, to, lat_of(32'h10)); end
        do_access(1'b0, 32'h10, 32'h0, waits, ew, de, rd, gp, dc, to);
        model_access(1'b0, 32'h10, 32'h0, dc, er, ee, kn);
        total++; if (to || waits != lat_of(32'h10)) begin bad++; $display("FAIL ram_rd_waits got=%0d timeout=%0b want=%0d", waits, to, lat_of(32'h10)); end
        total++; if (rd !== er) begin bad++; $display("FAIL ram_rd_data got=%h want=%h", rd, er); end
    endtask

    task automatic test_gpio();
        int waits; bit ew, to, ee, kn; logic de; logic [31:0] rd, er; logic [15:0] gp; int unsigned dc;
        do_access(1'b1, 32'hF000_0000, 32'h1234_A5A5, waits, ew, de, rd, gp, dc, to);
        model_access(1'b1, 32'hF000_0000, 32'h1234_A5A5, dc, er, ee, kn);
        total++; if (to || waits != IO_LAT) begin bad++; $display("FAIL gpio_wr_waits got=%0d timeout=%0b want=%0d", waits, to, IO_LAT); end
        total++; if (gp !== m_gpio) begin bad++; $display("FAIL gpio_out got=%h want=%h", gp, m_gpio); end
        sw_in = 16'h00FF;
        do_access(1'b0, 32'hF000_0000, 32'h0, waits, ew, de, rd, gp, dc, to);
        model_access(1'b0, 32'hF000_0000, 32'h0, dc, er, ee, kn);
        total++; if (rd !== er) begin bad++; $display("FAIL gpio_rd got=%h want=%h", rd, er); end
    endtask

    task automatic test_timer();
        int waits; bit ew, to, ee, kn; logic de; logic [31:0] rd, er; logic [15:0] gp; int unsigned dc;
        do_access(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, waits, ew, de, rd, gp, dc, to);
        model_access(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, dc, er, ee, kn);
        repeat (2) @(posedge clk);
        do_access(1'b0, 32'hF000_0004, 32'h0, waits, ew, de, rd, gp, dc, to);
        model_access(1'b0, 32'hF000_0004, 32'h0, dc, er, ee, kn);
        total++; if (to || rd !== er) begin bad++; $display("FAIL timer_wrap got=%h want=%h", rd, er); end
    endtask

    task automatic test_unmapped();
        int waits; bit ew, to, ee, kn; logic de; logic [31:0] rd, er; logic [15:0] gp; int unsigned dc;
        do_access(1'b0, 32'h8000_0000, 32'h0, waits, ew, de, rd, gp, dc, to);
        model_access(1'b0, 32'h8000_0000, 32'h0, dc, er, ee, kn);
        total++; if (to || waits != 1) begin bad++; $display("FAIL unmapped_waits got=%0d timeout=%0b want=1", waits, to); end
        total++; if (ew) begin bad++; $display("FAIL unmapped_err_in_wait got=1 want=0"); end
        total++; if (de !== ee) begin bad++; $display("FAIL unmapped_err_done got=%b want=%b", de, ee); end
        total++; if (rd !== er) begin bad++; $display("FAIL unmapped_rd got=%h want=%h", rd, er); end
        @(negedge clk);
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL unmapped_err_after got=%b want=0", bus_err); end
    endtask

    task automatic test_reset_in_wait();
        int waits; bit ew, to, ee, kn; logic de; logic [31:0] rd, er; logic [15:0] gp; int unsigned dc;
        do_access(1'b1, 32'h20, 32'h1111_1111, waits, ew, de, rd, gp, dc, to);
        model_access(1'b1, 32'h20, 32'h1111_1111, dc, er, ee, kn);
        @(negedge clk);
        mem_req = 1'b1; mem_w = 1'b1; M_addr = 32'h20; data_out = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        total++; if (MIO_ready !== 1'b0) begin bad++; $display("FAIL rst_wait_stall got=%b want=0", MIO_ready); end
        reset = 1'b0;
        #1;
        total++; if (MIO_ready !== 1'b1) begin bad++; $display("FAIL rst_wait_ready got=%b want=1", MIO_ready); end
        total++; if (data2CPU !== 32'h0) begin bad++; $display("FAIL rst_wait_data got=%h want=0", data2CPU); end
        mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        do_access(1'b0, 32'h20, 32'h0, waits, ew, de, rd, gp, dc, to);
        model_access(1'b0, 32'h20, 32'h0, dc, er, ee, kn);
        total++; if (to || rd !== er) begin bad++; $display("FAIL rst_wait_ram got=%h want=%h", rd, er); end
    endtask

    task automatic test_back_to_back();
        int waits; bit ee, kn, to; logic [31:0] er, d;
        d = $urandom;
        @(negedge clk);
        mem_req = 1'b1; mem_w = 1'b1; M_addr = 32'h40; data_out = d;
        @(posedge clk);
        waits = 0; to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (MIO_ready === 1'b1) begin to = 1'b0; break; end
            waits++;
        end
        model_access(1'b1, 32'h40, d, cyc, er, ee, kn);
        total++; if (to || waits != RAM_LAT) begin bad++; $display("FAIL b2b_first_waits got=%0d want=%0d", waits, RAM_LAT); end
        mem_w = 1'b0; M_addr = 32'h40;
        @(negedge clk);
        total++; if (MIO_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_after_done got=%b want=1", MIO_ready); end
        @(negedge clk);
        total++; if (MIO_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", MIO_ready); end
        waits = 1; to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (MIO_ready === 1'b1) begin to = 1'b0; break; end
            waits++;
        end
        model_access(1'b0, 32'h40, 32'h0, cyc, er, ee, kn);
        total++; if (to || waits != RAM_LAT || data2CPU !== er) begin
            bad++; $display("FAIL b2b_second_rd got=%h waits=%0d want=%h waits=%0d", data2CPU, waits, er, RAM_LAT);
        end
        mem_req = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_random();
        int waits; bit ew, to, ee, kn; logic de; logic [31:0] rd, er, addr, data; logic [15:0] gp;
        int unsigned dc; logic w;
        for (int i = 0; i < 8; i++) begin
            data = $urandom;
            do_access(1'b1, 32'(i * 4), data, waits, ew, de, rd, gp, dc, to);
            model_access(1'b1, 32'(i * 4), data, dc, er, ee, kn);
        end
        for (int n = 0; n < 48; n++) begin
            sw_in = 16'($urandom);
            w     = 1'($urandom_range(0, 1));
            data  = $urandom;
            case ($urandom_range(0, 3))
                0:       addr = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 3));
                1:       addr = 32'hF000_0000 | 32'($urandom_range(0, 3));
                2:       addr = 32'hF000_0004 | 32'($urandom_range(0, 3));
                default: addr = $urandom | 32'h0000_0100;
            endcase
            do_access(w, addr, data, waits, ew, de, rd, gp, dc, to);
            model_access(w, addr, data, dc, er, ee, kn);
            total++; if (to || waits != lat_of(addr) || ew) begin
                bad++; $display("FAIL rnd_timing n=%0d addr=%h got=%0d err_wait=%0b want=%0d", n, addr, waits, ew, lat_of(addr));
            end
            total++; if (de !== ee) begin bad++; $display("FAIL rnd_bus_err n=%0d addr=%h got=%b want=%b", n, addr, de, ee); end
            total++; if (gp !== m_gpio) begin bad++; $display("FAIL rnd_gpio n=%0d got=%h want=%h", n, gp, m_gpio); end
            if (kn) begin
                total++; if (rd !== er) begin bad++; $display("FAIL rnd_data n=%0d addr=%h w=%b got=%h want=%h", n, addr, w, rd, er); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_timer();
        test_unmapped();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
